// File: rtl/cv32e40p_obi_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : cv32e40p_obi_mem_responder
// Purpose  : OBI data-port target with a word RAM, programmable grant stall and
//            fixed-latency, strictly in-order responses.
// Revision : 1.0
// ============================================================================
module cv32e40p_obi_mem_responder #(
  parameter int unsigned DEPTH           = 1024,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
  parameter int unsigned GNT_STALL       = 0,
  parameter int unsigned RVALID_LAT      = 1,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] ERR_RDATA       = 32'hDEAD_BEEF
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o
);

  localparam int unsigned c_AW  = $clog2(DEPTH);
  localparam int unsigned c_PW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned c_CW  = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [32:0]     c_SPAN   = 33'(DEPTH) << 2;
  localparam logic [3:0]      c_STALL  = 4'(GNT_STALL);
  localparam logic [3:0]      c_LAT_M1 = 4'(RVALID_LAT - 1);
  localparam logic [c_CW-1:0] c_MAX    = c_CW'(MAX_OUTSTANDING);
  localparam logic [c_PW-1:0] c_LAST   = c_PW'(MAX_OUTSTANDING - 1);

  logic [31:0]     r_mem [DEPTH];
  logic [3:0]      r_stall_cnt;
  logic [c_CW-1:0] r_count;
  logic [c_PW-1:0] r_rd_ptr;
  logic [c_PW-1:0] r_wr_ptr;
  logic [31:0]     r_q_data [MAX_OUTSTANDING];
  logic [3:0]      r_q_age  [MAX_OUTSTANDING];

  logic [31:0]     w_off;
  logic            w_in_range;
  logic [c_AW-1:0] w_idx;
  logic [31:0]     w_rd_word;
  logic            w_stall_done;
  logic            w_retire;
  logic            w_room;
  logic            w_gnt;

  // Unsigned wrap-around makes addresses below BASE_ADDR fall out of range too.
  assign w_off      = addr_i - BASE_ADDR;
  assign w_in_range = ({1'b0, w_off} < c_SPAN);
  assign w_idx      = w_off[c_AW+1:2];
  assign w_rd_word  = w_in_range ? r_mem[w_idx] : ERR_RDATA;

  assign w_stall_done = (r_stall_cnt >= c_STALL);
  assign w_retire     = (r_count != '0) && (r_q_age[r_rd_ptr] == c_LAT_M1);
  assign w_room       = (r_count < c_MAX) || w_retire;
  assign w_gnt        = rst_ni && req_i && w_stall_done && w_room;

  assign gnt_o    = w_gnt;
  assign rvalid_o = rst_ni && w_retire;
  assign rdata_o  = rvalid_o ? r_q_data[r_rd_ptr] : 32'h0;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_stall_cnt <= '0;
      r_count     <= '0;
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
    end else begin
      if (!req_i || w_gnt) begin
        r_stall_cnt <= '0;
      end else if (r_stall_cnt != 4'hF) begin
        r_stall_cnt <= r_stall_cnt + 4'd1;
      end

      if (w_gnt) begin
        r_wr_ptr <= (r_wr_ptr == c_LAST) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_retire) begin
        r_rd_ptr <= (r_rd_ptr == c_LAST) ? '0 : r_rd_ptr + 1'b1;
      end

      if (w_gnt && !w_retire) begin
        r_count <= r_count + 1'b1;
      end else if (!w_gnt && w_retire) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // Every slot ages each cycle; only occupied slots are ever inspected.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int s = 0; s < MAX_OUTSTANDING; s++) begin
        r_q_data[s] <= '0;
        r_q_age[s]  <= '0;
      end
    end else begin
      for (int s = 0; s < MAX_OUTSTANDING; s++) begin
        if (w_gnt && (r_wr_ptr == c_PW'(s))) begin
          r_q_data[s] <= we_i ? 32'h0 : w_rd_word;
          r_q_age[s]  <= '0;
        end else if (r_q_age[s] != 4'hF) begin
          r_q_age[s] <= r_q_age[s] + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_gnt && we_i && w_in_range) begin
      for (int k = 0; k < 4; k++) begin
        if (be_i[k]) begin
          r_mem[w_idx][8*k +: 8] <= wdata_i[8*k +: 8];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cv32e40p_obi_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_cv32e40p_obi_mem_responder
// Purpose  : Directed and randomized checks of the OBI memory responder.
// Revision : 1.0
// ============================================================================
module tb_cv32e40p_obi_mem_responder;

  localparam logic [31:0] R_BASE  = 32'h8000_0000;
  localparam int          R_DEPTH = 1024;
  localparam int          R_STALL = 1;
  localparam int          R_LAT   = 2;
  localparam int          R_MAX   = 2;
  localparam logic [31:0] R_ERR   = 32'hDEAD_BEEF;

  logic        clk;
  logic        rst_n [4];
  logic        req   [4];
  logic        we    [4];
  logic [31:0] addr  [4];
  logic [3:0]  be    [4];
  logic [31:0] wdata [4];
  logic        gnt   [4];
  logic        rvalid[4];
  logic [31:0] rdata [4];

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          due;
    logic [31:0] data;
  } resp_t;

  resp_t       mq[$];
  logic [31:0] mmem [R_DEPTH];
  int          mheld;
  int          mcyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  cv32e40p_obi_mem_responder u_def (
    .clk_i(clk), .rst_ni(rst_n[0]), .req_i(req[0]), .gnt_o(gnt[0]), .addr_i(addr[0]),
    .we_i(we[0]), .be_i(be[0]), .wdata_i(wdata[0]), .rvalid_o(rvalid[0]), .rdata_o(rdata[0]));

  cv32e40p_obi_mem_responder #(.GNT_STALL(3)) u_stall (
    .clk_i(clk), .rst_ni(rst_n[1]), .req_i(req[1]), .gnt_o(gnt[1]), .addr_i(addr[1]),
    .we_i(we[1]), .be_i(be[1]), .wdata_i(wdata[1]), .rvalid_o(rvalid[1]), .rdata_o(rdata[1]));

  cv32e40p_obi_mem_responder #(.RVALID_LAT(4), .MAX_OUTSTANDING(2)) u_lat (
    .clk_i(clk), .rst_ni(rst_n[2]), .req_i(req[2]), .gnt_o(gnt[2]), .addr_i(addr[2]),
    .we_i(we[2]), .be_i(be[2]), .wdata_i(wdata[2]), .rvalid_o(rvalid[2]), .rdata_o(rdata[2]));

  cv32e40p_obi_mem_responder #(
    .DEPTH(R_DEPTH), .BASE_ADDR(R_BASE), .GNT_STALL(R_STALL), .RVALID_LAT(R_LAT),
    .MAX_OUTSTANDING(R_MAX), .ERR_RDATA(R_ERR)
  ) u_rnd (
    .clk_i(clk), .rst_ni(rst_n[3]), .req_i(req[3]), .gnt_o(gnt[3]), .addr_i(addr[3]),
    .we_i(we[3]), .be_i(be[3]), .wdata_i(wdata[3]), .rvalid_o(rvalid[3]), .rdata_o(rdata[3]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One directed cycle: drive, sample mid-cycle, then advance past the edge.
  task automatic step(input int d, input logic rq, input logic w, input logic [31:0] a,
                      input logic [3:0] b, input logic [31:0] wd, input logic eg,
                      input logic erv, input logic [31:0] erd, input string tag);
    req[d] = rq; we[d] = w; addr[d] = a; be[d] = b; wdata[d] = wd;
    @(negedge clk);
    chk({tag, "_gnt"},    32'(gnt[d]),    32'(eg));
    chk({tag, "_rvalid"}, 32'(rvalid[d]), 32'(erv));
    chk({tag, "_rdata"},  rdata[d],       erd);
    @(posedge clk); #1;
  endtask

  // Reference model cycle: pending responses are kept as (due cycle, data) pairs.
  task automatic rcycle(input logic rq, input logic w, input logic [31:0] a,
                        input logic [3:0] b, input logic [31:0] wd, output logic granted);
    logic [31:0] off;
    logic        inr;
    logic        ret;
    logic        eg;
    logic [31:0] erd;
    int          idx;
    resp_t       e;
    req[3] = rq; we[3] = w; addr[3] = a; be[3] = b; wdata[3] = wd;
    off = a - R_BASE;
    inr = (off < 32'(R_DEPTH * 4));
    idx = int'(off[11:2]);
    ret = (mq.size() > 0) && (mq[0].due == mcyc);
    eg  = rq && (mheld >= R_STALL) && ((mq.size() < R_MAX) || ret);
    erd = ret ? mq[0].data : 32'h0;
    @(negedge clk);
    chk("rnd_gnt",    32'(gnt[3]),    32'(eg));
    chk("rnd_rvalid", 32'(rvalid[3]), 32'(ret));
    chk("rnd_rdata",  rdata[3],       erd);
    if (ret) void'(mq.pop_front());
    if (eg) begin
      if (w) begin
        if (inr) begin
          for (int k = 0; k < 4; k++) if (b[k]) mmem[idx][8*k +: 8] = wd[8*k +: 8];
        end
        e.data = 32'h0;
      end else begin
        e.data = inr ? mmem[idx] : R_ERR;
      end
      e.due = mcyc + R_LAT;
      mq.push_back(e);
    end
    mheld = (eg || !rq) ? 0 : ((mheld < 15) ? mheld + 1 : 15);
    mcyc++;
    granted = eg;
    @(posedge clk); #1;
  endtask

  task automatic rtxn(input logic w, input logic [31:0] a, input logic [3:0] b,
                      input logic [31:0] wd);
    logic g;
    int   n;
    g = 1'b0;
    n = 0;
    while (!g && n < 20) begin
      rcycle(1'b1, w, a, b, wd, g);
      n++;
    end
    checks++;
    assert (g === 1'b1) else begin
      failures++;
      $error("FAIL rnd_txn_timeout observed=no_grant_after_%0d expected=grant", n);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        g;
    logic [31:0] a;
    for (int i = 0; i < 4; i++) begin
      rst_n[i] = 1'b0; req[i] = 1'b0; we[i] = 1'b0;
      addr[i] = '0; be[i] = '0; wdata[i] = '0;
    end
    mheld = 0;
    mcyc  = 0;
    @(posedge clk); #1;

    // Reset holds outputs low even with a request pending.
    step(0, 1, 1, 32'h10, 4'hF, 32'h5555_5555, 0, 0, 32'h0, "rst0");
    step(0, 1, 1, 32'h10, 4'hF, 32'h5555_5555, 0, 0, 32'h0, "rst1");
    for (int i = 0; i < 4; i++) rst_n[i] = 1'b1;
    step(0, 0, 0, 32'h0, 4'h0, 32'h0, 0, 0, 32'h0, "d_idle");

    // Defaults: same-cycle grant, one-cycle response latency, byte lanes.
    step(0, 1, 1, 32'h10, 4'hF,    32'h1234_5678, 1, 0, 32'h0,         "d_wr");
    step(0, 0, 0, 32'h0,  4'h0,    32'h0,         0, 1, 32'h0,         "d_wr_rsp");
    step(0, 1, 0, 32'h10, 4'hF,    32'h0,         1, 0, 32'h0,         "d_rd");
    step(0, 0, 0, 32'h0,  4'h0,    32'h0,         0, 1, 32'h1234_5678, "d_rd_rsp");
    step(0, 1, 1, 32'h10, 4'hF,    32'hAABB_CCDD, 1, 0, 32'h0,         "d_bl_wr0");
    step(0, 1, 1, 32'h10, 4'b0101, 32'h1122_3344, 1, 1, 32'h0,         "d_bl_wr1");
    step(0, 1, 0, 32'h10, 4'h0,    32'h0,         1, 1, 32'h0,         "d_bl_rd");
    step(0, 0, 0, 32'h0,  4'h0,    32'h0,         0, 1, 32'hAA22_CC44, "d_bl_rsp");

    // GNT_STALL = 3: grant on the fourth cycle of a held request.
    step(1, 1, 1, 32'h20, 4'hF, 32'hCAFE_0001, 0, 0, 32'h0, "s_c0");
    step(1, 1, 1, 32'h20, 4'hF, 32'hCAFE_0001, 0, 0, 32'h0, "s_c1");
    step(1, 1, 1, 32'h20, 4'hF, 32'hCAFE_0001, 0, 0, 32'h0, "s_c2");
    step(1, 1, 1, 32'h20, 4'hF, 32'hCAFE_0001, 1, 0, 32'h0, "s_c3");
    step(1, 0, 0, 32'h0,  4'h0, 32'h0,         0, 1, 32'h0, "s_rsp");
    step(1, 1, 1, 32'h24, 4'hF, 32'hCAFE_0002, 0, 0, 32'h0, "s_drop_c0");
    step(1, 1, 1, 32'h24, 4'hF, 32'hCAFE_0002, 0, 0, 32'h0, "s_drop_c1");
    step(1, 0, 1, 32'h24, 4'hF, 32'hCAFE_0002, 0, 0, 32'h0, "s_drop_c2");
    step(1, 1, 1, 32'h24, 4'hF, 32'hCAFE_0002, 0, 0, 32'h0, "s_re_c0");
    step(1, 1, 1, 32'h24, 4'hF, 32'hCAFE_0002, 0, 0, 32'h0, "s_re_c1");
    step(1, 1, 1, 32'h24, 4'hF, 32'hCAFE_0002, 0, 0, 32'h0, "s_re_c2");
    step(1, 1, 1, 32'h24, 4'hF, 32'hCAFE_0002, 1, 0, 32'h0, "s_re_c3");
    step(1, 0, 0, 32'h0,  4'h0, 32'h0,         0, 1, 32'h0, "s_re_rsp");
    step(1, 1, 0, 32'h24, 4'h0, 32'h0,         0, 0, 32'h0, "s_rd_c0");
    step(1, 1, 0, 32'h24, 4'h0, 32'h0,         0, 0, 32'h0, "s_rd_c1");
    step(1, 1, 0, 32'h24, 4'h0, 32'h0,         0, 0, 32'h0, "s_rd_c2");
    step(1, 1, 0, 32'h24, 4'h0, 32'h0,         1, 0, 32'h0, "s_rd_c3");
    step(1, 0, 0, 32'h0,  4'h0, 32'h0,         0, 1, 32'hCAFE_0002, "s_rd_rsp");

    // RVALID_LAT = 4, MAX_OUTSTANDING = 2 with the request held high.
    step(2, 1, 1, 32'h0, 4'hF, 32'h0101_A0A0, 1, 0, 32'h0, "l_c0");
    step(2, 1, 1, 32'h4, 4'hF, 32'h0202_B1B1, 1, 0, 32'h0, "l_c1");
    step(2, 1, 1, 32'h8, 4'hF, 32'h0303_C2C2, 0, 0, 32'h0, "l_c2");
    step(2, 1, 1, 32'h8, 4'hF, 32'h0303_C2C2, 0, 0, 32'h0, "l_c3");
    step(2, 1, 1, 32'h8, 4'hF, 32'h0303_C2C2, 1, 1, 32'h0, "l_c4");
    step(2, 1, 0, 32'h0, 4'hF, 32'h0,         1, 1, 32'h0, "l_c5");
    step(2, 1, 0, 32'h4, 4'hF, 32'h0,         0, 0, 32'h0, "l_c6");
    step(2, 1, 0, 32'h4, 4'hF, 32'h0,         0, 0, 32'h0, "l_c7");
    step(2, 1, 0, 32'h4, 4'hF, 32'h0,         1, 1, 32'h0, "l_c8");
    step(2, 1, 0, 32'h8, 4'hF, 32'h0,         1, 1, 32'h0101_A0A0, "l_c9");
    step(2, 0, 0, 32'h0, 4'h0, 32'h0,         0, 0, 32'h0, "l_c10");
    step(2, 0, 0, 32'h0, 4'h0, 32'h0,         0, 0, 32'h0, "l_c11");
    step(2, 0, 0, 32'h0, 4'h0, 32'h0,         0, 1, 32'h0202_B1B1, "l_c12");
    step(2, 0, 0, 32'h0, 4'h0, 32'h0,         0, 1, 32'h0303_C2C2, "l_c13");
    step(2, 0, 0, 32'h0, 4'h0, 32'h0,         0, 0, 32'h0, "l_c14");

    // Reset with two reads in flight: both responses are dropped.
    step(2, 1, 0, 32'h0, 4'hF, 32'h0, 1, 0, 32'h0, "lr_rd0");
    step(2, 1, 0, 32'h4, 4'hF, 32'h0, 1, 0, 32'h0, "lr_rd1");
    rst_n[2] = 1'b0;
    step(2, 0, 0, 32'h0, 4'h0, 32'h0, 0, 0, 32'h0, "lr_rst");
    rst_n[2] = 1'b1;
    for (int i = 0; i < 4; i++) step(2, 0, 0, 32'h0, 4'h0, 32'h0, 0, 0, 32'h0, "lr_quiet");
    step(2, 1, 0, 32'h8, 4'hF, 32'h0, 1, 0, 32'h0, "lr_new0");
    step(2, 1, 0, 32'h0, 4'hF, 32'h0, 1, 0, 32'h0, "lr_new1");
    step(2, 0, 0, 32'h0, 4'h0, 32'h0, 0, 0, 32'h0, "lr_w0");
    step(2, 0, 0, 32'h0, 4'h0, 32'h0, 0, 0, 32'h0, "lr_w1");
    step(2, 0, 0, 32'h0, 4'h0, 32'h0, 0, 1, 32'h0303_C2C2, "lr_rsp0");
    step(2, 0, 0, 32'h0, 4'h0, 32'h0, 0, 1, 32'h0101_A0A0, "lr_rsp1");
    step(2, 0, 0, 32'h0, 4'h0, 32'h0, 0, 0, 32'h0, "lr_end");

    // Randomized run against the reference model, offset base and stall.
    for (int i = 0; i < R_DEPTH; i++) rtxn(1'b1, R_BASE + 32'(i * 4), 4'hF, $urandom);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) a = $urandom;
      else a = R_BASE + {20'h0, 10'($urandom_range(0, R_DEPTH - 1)), 2'($urandom_range(0, 3))};
      rcycle($urandom_range(0, 9) < 8, 1'($urandom_range(0, 1)), a,
             4'($urandom_range(0, 15)), $urandom, g);
    end
    rtxn(1'b1, 32'h7FFF_FFFC, 4'hF, 32'h5A5A_5A5A);
    rtxn(1'b0, 32'h8000_1000, 4'hF, 32'h0);
    for (int i = 0; i < R_DEPTH; i++) rtxn(1'b0, R_BASE + 32'(i * 4), 4'hF, 32'h0);
    for (int i = 0; i < 6; i++) rcycle(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, g);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
